// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts one instruction, reads both sources from a
// registered-read register file, applies write-back bypass, and holds the result.
module operand_fetch #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_inst,
   input  logic [XLEN-1:0] in_pc,
   output logic [4:0]      rf_raddr1,
   output logic [4:0]      rf_raddr2,
   output logic            rf_ren1,
   output logic            rf_ren2,
   input  logic [XLEN-1:0] rf_rdata1,
   input  logic [XLEN-1:0] rf_rdata2,
   input  logic            wb_valid,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_inst,
   output logic [XLEN-1:0] out_src1,
   output logic [XLEN-1:0] out_src2
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] VALID = 2'd3;

   logic [1:0]      state_r;
   logic [1:0]      state_s;
   logic [XLEN-1:0] inst_r;
   logic [XLEN-1:0] pc_r;
   logic [XLEN-1:0] src1_r;
   logic [XLEN-1:0] src2_r;
   logic [XLEN-1:0] byp1_data_r;
   logic [XLEN-1:0] byp2_data_r;
   logic            byp1_r;
   logic            byp2_r;
   logic            ren_r;
   logic            valid_r;
   logic            accept_s;
   logic            hit1_s;
   logic            hit2_s;
   logic [4:0]      rs1_s;
   logic [4:0]      rs2_s;

   // Final operand choice at the WAIT edge: x0 forces zero, the newest write wins.
   function automatic logic [XLEN-1:0] pick_operand(
      input logic [4:0]      rs,
      input logic            hit_now,
      input logic [XLEN-1:0] wb_value,
      input logic            hit_issue,
      input logic [XLEN-1:0] issue_value,
      input logic [XLEN-1:0] rf_value
   );
      if (rs == 5'd0) begin
         return {XLEN{1'b0}};
      end else if (hit_now) begin
         return wb_value;
      end else if (hit_issue) begin
         return issue_value;
      end else begin
         return rf_value;
      end
   endfunction

   assign rs1_s    = inst_r[19:15];
   assign rs2_s    = inst_r[24:20];
   assign hit1_s   = wb_valid && (wb_rd == rs1_s) && (rs1_s != 5'd0);
   assign hit2_s   = wb_valid && (wb_rd == rs2_s) && (rs2_s != 5'd0);
   assign in_ready = (state_r == IDLE) || ((state_r == VALID) && out_ready);
   assign accept_s = in_valid && in_ready;

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    state_s = accept_s ? ISSUE : IDLE;
         ISSUE:   state_s = WAIT;
         WAIT:    state_s = VALID;
         VALID:   state_s = out_ready ? (accept_s ? ISSUE : IDLE) : VALID;
         default: state_s = IDLE;
      endcase
   end

   // State, payload, bypass capture and operand registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         inst_r      <= {XLEN{1'b0}};
         pc_r        <= {XLEN{1'b0}};
         src1_r      <= {XLEN{1'b0}};
         src2_r      <= {XLEN{1'b0}};
         byp1_data_r <= {XLEN{1'b0}};
         byp2_data_r <= {XLEN{1'b0}};
         byp1_r      <= 1'b0;
         byp2_r      <= 1'b0;
         ren_r       <= 1'b0;
         valid_r     <= 1'b0;
      end else begin
         state_r <= state_s;
         ren_r   <= (state_s == ISSUE);
         valid_r <= (state_s == VALID);
         if (accept_s) begin
            inst_r <= in_inst;
            pc_r   <= in_pc;
         end
         // The register file returns pre-write data for a write at the ISSUE edge.
         if (state_r == ISSUE) begin
            byp1_r      <= hit1_s;
            byp2_r      <= hit2_s;
            byp1_data_r <= wb_data;
            byp2_data_r <= wb_data;
         end
         if (state_r == WAIT) begin
            src1_r <= pick_operand(rs1_s, hit1_s, wb_data, byp1_r, byp1_data_r, rf_rdata1);
            src2_r <= pick_operand(rs2_s, hit2_s, wb_data, byp2_r, byp2_data_r, rf_rdata2);
         end else if ((state_r == VALID) && !out_ready) begin
            if (hit1_s) begin
               src1_r <= wb_data;
            end
            if (hit2_s) begin
               src2_r <= wb_data;
            end
         end
      end
   end

   assign rf_raddr1 = rs1_s;
   assign rf_raddr2 = rs2_s;
   assign rf_ren1   = ren_r;
   assign rf_ren2   = ren_r;
   assign out_valid = valid_r;
   assign out_pc    = pc_r;
   assign out_inst  = inst_r;
   assign out_src1  = src1_r;
   assign out_src2  = src2_r;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a register file model plus a reference that expects
// each held operand to equal the architectural register value, checked every cycle.
module tb_operand_fetch;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_inst, in_pc, rf_rdata1, rf_rdata2, wb_data;
   logic [31:0] out_pc, out_inst, out_src1, out_src2;
   logic [4:0]  rf_raddr1, rf_raddr2, wb_rd;
   logic        rf_ren1, rf_ren2, wb_valid;

   always #5 clk = ~clk;

   operand_fetch #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_ren1(rf_ren1), .rf_ren2(rf_ren2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst), .out_src1(out_src1), .out_src2(out_src2)
   );

   // Register file: write commits at the edge, reads return the pre-write value one cycle later.
   logic [31:0] regs [0:31] = '{default: 32'd0};
   always @(posedge clk) begin
      if (wb_valid && wb_rd != 5'd0) regs[wb_rd] <= wb_data;
      if (rf_ren1) rf_rdata1 <= regs[rf_raddr1]; else rf_rdata1 <= $urandom;
      if (rf_ren2) rf_rdata2 <= regs[rf_raddr2]; else rf_rdata2 <= $urandom;
   end

   int tests = 0;
   int fails = 0;

   // Reference: an accepted instruction becomes visible 3 cycles after its accept cycle.
   bit          busy = 1'b0;
   int          age = 0;
   bit          known = 1'b0;
   bit          after_rst = 1'b0;
   logic [31:0] m_inst = 32'd0;
   logic [31:0] m_pc = 32'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] arch(input logic [4:0] rs);
      return (rs == 5'd0) ? 32'd0 : regs[rs];
   endfunction

   function automatic logic [31:0] mk(input logic [4:0] a, input logic [4:0] b);
      logic [31:0] t;
      t = $urandom;
      t[19:15] = a;
      t[24:20] = b;
      return t;
   endfunction

   task automatic cycle(input logic iv, input logic [31:0] ii, input logic [31:0] ip,
                        input logic ordy, input logic wv, input logic [4:0] wr,
                        input logic [31:0] wd, input logic r, output logic acc);
      bit exp_v, exp_rdy;
      in_valid = iv; in_inst = ii; in_pc = ip; out_ready = ordy;
      wb_valid = wv; wb_rd = wr; wb_data = wd; rst = r;
      #1;
      exp_v   = busy && (age == 3);
      exp_rdy = !busy || (exp_v && ordy);
      acc = iv && in_ready && !r;
      if (!r && known) begin
         chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
         chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
         chk("rf_ren1", {31'd0, rf_ren1}, {31'd0, busy && (age == 1)});
         chk("rf_ren2", {31'd0, rf_ren2}, {31'd0, busy && (age == 1)});
         chk("rf_raddr1", {27'd0, rf_raddr1}, {27'd0, m_inst[19:15]});
         chk("rf_raddr2", {27'd0, rf_raddr2}, {27'd0, m_inst[24:20]});
         if (exp_v) begin
            chk("out_inst", out_inst, m_inst);
            chk("out_pc", out_pc, m_pc);
            chk("out_src1", out_src1, arch(m_inst[19:15]));
            chk("out_src2", out_src2, arch(m_inst[24:20]));
         end
         if (after_rst) begin
            chk("rst_pc", out_pc, 32'd0);
            chk("rst_inst", out_inst, 32'd0);
            chk("rst_src1", out_src1, 32'd0);
            chk("rst_src2", out_src2, 32'd0);
            after_rst = 1'b0;
         end
      end
      if (r) begin
         busy = 1'b0; age = 0; m_inst = 32'd0; m_pc = 32'd0;
         known = 1'b1; after_rst = 1'b1;
      end else if (iv && exp_rdy) begin
         busy = 1'b1; age = 1; m_inst = ii; m_pc = ip;
      end else if (exp_v && ordy) begin
         busy = 1'b0;
      end else if (busy && age < 3) begin
         age++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      logic a;
      for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, a);
   endtask

   task automatic wb(input logic [4:0] rd, input logic [31:0] d);
      logic a;
      cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, rd, d, 1'b0, a);
   endtask

   initial begin
      logic        a;
      logic [31:0] q [2];
      int          k, t, t0, t1;

      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, a);
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, a);
      chk("ready_after_rst", {31'd0, in_ready}, 32'd1);
      wb(5'd1, 32'h11);
      wb(5'd2, 32'h22);
      wb(5'd5, 32'h05);

      // Basic read with echoed pc/inst
      cycle(1'b1, mk(5'd1, 5'd2), 32'h100, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, a);
      chk("basic_acc", {31'd0, a}, 32'd1);
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, a);
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, a);
      chk("basic_src1", out_src1, 32'h11);
      chk("basic_src2", out_src2, 32'h22);
      idle(2);

      // Write in ISSUE then WAIT: the later one wins
      cycle(1'b1, mk(5'd1, 5'd3), 32'h200, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, a);
      cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 5'd1, 32'hAA, 1'b0, a);
      cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 5'd1, 32'hBB, 1'b0, a);
      chk("byp_wait", out_src1, 32'hBB);
      idle(2);

      // Write in ISSUE only
      cycle(1'b1, mk(5'd1, 5'd3), 32'h300, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, a);
      cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 5'd1, 32'hAA, 1'b0, a);
      cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, a);
      chk("byp_issue", out_src1, 32'hAA);
      idle(2);

      // x0 source and a stall with a write to the held operand
      cycle(1'b1, mk(5'd0, 5'd5), 32'h400, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, a);
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, a);
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 32'hFF, 1'b0, a);
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, a);
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd5, 32'h55, 1'b0, a);
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, a);
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, a);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_src1", out_src1, 32'd0);
      chk("stall_src2", out_src2, 32'h55);
      idle(2);

      // Back-to-back with in_valid held
      q[0] = mk(5'd2, 5'd1);
      q[1] = mk(5'd5, 5'd2);
      k = 0; t0 = 0; t1 = 0;
      for (t = 0; t < 10; t++) begin
         cycle(k < 2, (k < 2) ? q[k] : 32'd0, 32'h500 + k, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, a);
         if (a) begin
            if (k == 0) t0 = t; else t1 = t;
            k++;
         end
      end
      chk("b2b_count", k, 2);
      chk("b2b_gap", t1 - t0, 3);

      // Reset in WAIT discards the instruction
      cycle(1'b1, mk(5'd1, 5'd2), 32'h600, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, a);
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, a);
      cycle(1'b1, mk(5'd2, 5'd2), 32'h700, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, a);
      chk("rstw_valid", {31'd0, out_valid}, 32'd0);
      chk("rstw_raddr", {22'd0, rf_raddr1, rf_raddr2}, 32'd0);
      idle(5);

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         cycle(1'($urandom_range(0, 1)),
               mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))), $urandom,
               ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 49) == 0), a);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
